sc_lastregbackg_controller: RTL and testbench
=============================================

Name: sc_lastregbackg_controller

Overview:
- Control FSM directly upstream of the last-row background register (SC_LastRegBACKGTYPE).
- Generates that register's clear, load, shift-selection, level-index and final-register-load strobes.
- Sequences game start, periodic row scrolling, goal capture when the frog reaches the last row, and level advance/win once every goal slot is filled.

Parameters:
- DATAWIDTH, 8: width of the last-row pattern; must match the downstream register.
- TICK_DIV, 25000000: clocks per scroll step (0.5 s at 50 MHz); legal range 2 to 2^CNT_WIDTH.
- CNT_WIDTH, 25: prescaler counter width.

Ports:
- SC_LastRegBACKGTYPE_CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- SC_LastRegBACKGTYPE_RESET_InHigh  in  1  asynchronous reset, active-high.
- SC_LastRegBACKGTYPE_start_InLow  in  1  start/restart request, active-low, level-sampled each clock.
- SC_LastRegBACKGTYPE_frogArrive_InLow  in  1  frog reached last row, active-low, one-cycle pulse.
- SC_LastRegBACKGTYPE_lastpointreg_InBUS  in  DATAWIDTH  accumulated goal pattern; all ones means every goal is filled.
- SC_LastRegBACKGTYPE_clear_OutLow  out  1  clear strobe to the register.
- SC_LastRegBACKGTYPE_load_OutLow  out  1  level-pattern load strobe.
- SC_LastRegBACKGTYPE_shiftselection_Out  out  2  01 = rotate left, 10 = rotate right, 00 = hold.
- SC_LastRegBACKGTYPE_transitioncounter_OutBUS  out  2  current level index, 0 to 3.
- SC_LastRegBACKGTYPE_LoadFinalRegister_OutLow  out  1  merge last-point pattern strobe.
- SC_LastRegBACKGTYPE_levelDone_Out  out  1  one-cycle pulse on level advance.
- SC_LastRegBACKGTYPE_gameWin_Out  out  1  high while in WIN.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE, prescaler = 0, level = 0.
  - clear/load/LoadFinal outputs = 1, shiftselection = 00, transitioncounter = 00, levelDone = 0, gameWin = 0.
- All outputs are registered. Each strobe is asserted for exactly one clock, in the cycle the FSM occupies the named state.
- FSM states: IDLE, CLEAR, LOAD, RUN, FINAL, CHECK, NEXTLVL, WIN.
- IDLE: start_InLow = 0 -> CLEAR.
- CLEAR: clear_OutLow = 0, level reset to 0 -> LOAD.
- LOAD: load_OutLow = 0, prescaler cleared -> RUN.
- RUN:
  - Prescaler increments each clock.
  - At prescaler = TICK_DIV-1: prescaler wraps to 0 and shiftselection is driven for one cycle. Level 0 or 2 drives 01; level 1 or 3 drives 10.
  - Otherwise shiftselection = 00.
- RUN exits, by priority:
  1. start_InLow = 0 -> CLEAR (restart).
  2. frogArrive_InLow = 0 -> FINAL. A shift tick in the same cycle is suppressed and the prescaler holds its value.
- FINAL: LoadFinalRegister_OutLow = 0 -> CHECK.
- CHECK: samples lastpointreg_InBUS one clock after the FINAL strobe.
  - All ones -> NEXTLVL.
  - Otherwise -> RUN; prescaler resumes from its held value.
- NEXTLVL:
  - Level = 3 -> WIN; level is not incremented and no levelDone pulse is issued.
  - Level < 3 -> level + 1, levelDone_Out = 1 -> LOAD, which reloads the new level pattern.
- WIN: gameWin_Out = 1 (level output) and shiftselection = 00. start_InLow = 0 -> CLEAR, which drops gameWin and resets level to 0.
- Strobes are never asserted simultaneously, and no two strobes occur on consecutive cycles except the fixed CLEAR->LOAD and FINAL sequences.
- frogArrive pulses outside RUN are ignored and not queued.
- start_InLow held low continuously: after CLEAR->LOAD the FSM reaches RUN, then immediately restarts to CLEAR. Holding start low is therefore a continuous restart loop by design.

Test Plan (TICK_DIV = 4):
- Reset asserted mid-RUN -> all outputs return to reset values asynchronously; after release the FSM sits in IDLE with no strobes.
- start_InLow low for 1 clock in IDLE -> clear_OutLow low on cycle 1, load_OutLow low on cycle 2; in RUN, shiftselection = 01 for 1 cycle every 4 clocks.
- frogArrive pulse coincident with a shift tick, lastpointreg = 8'b00010001 -> no shift that cycle; LoadFinalRegister_OutLow low 1 cycle; return to RUN; next shift occurs 4 clocks after the resumed count.
- frogArrive with lastpointreg = 8'hFF at level 0 -> levelDone pulse, transitioncounter = 01, load strobe, subsequent shifts = 10.
- Level 3 with lastpointreg = 8'hFF -> gameWin_Out = 1, shiftselection stays 00; a later start pulse -> gameWin = 0, transitioncounter = 00, clear then load.
- frogArrive pulses in IDLE and WIN -> no strobes, no state change.

Source files
------------

// File: rtl/sc_lastregbackg_controller.sv
// ============================================================================
// sc_lastregbackg_controller: FSM driving the last-row background register.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_lastregbackg_controller #(
  parameter int DATAWIDTH = 8,
  parameter int TICK_DIV  = 25000000,
  parameter int CNT_WIDTH = 25
) (
  input  logic                 SC_LastRegBACKGTYPE_CLOCK_50,
  input  logic                 SC_LastRegBACKGTYPE_RESET_InHigh,
  input  logic                 SC_LastRegBACKGTYPE_start_InLow,
  input  logic                 SC_LastRegBACKGTYPE_frogArrive_InLow,
  input  logic [DATAWIDTH-1:0] SC_LastRegBACKGTYPE_lastpointreg_InBUS,
  output logic                 SC_LastRegBACKGTYPE_clear_OutLow,
  output logic                 SC_LastRegBACKGTYPE_load_OutLow,
  output logic [1:0]           SC_LastRegBACKGTYPE_shiftselection_Out,
  output logic [1:0]           SC_LastRegBACKGTYPE_transitioncounter_OutBUS,
  output logic                 SC_LastRegBACKGTYPE_LoadFinalRegister_OutLow,
  output logic                 SC_LastRegBACKGTYPE_levelDone_Out,
  output logic                 SC_LastRegBACKGTYPE_gameWin_Out
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_clear   = 3'd1;
  localparam logic [2:0] c_load    = 3'd2;
  localparam logic [2:0] c_run     = 3'd3;
  localparam logic [2:0] c_final   = 3'd4;
  localparam logic [2:0] c_check   = 3'd5;
  localparam logic [2:0] c_nextlvl = 3'd6;
  localparam logic [2:0] c_win     = 3'd7;

  localparam logic [CNT_WIDTH-1:0] c_tick_last = CNT_WIDTH'(TICK_DIV - 1);
  localparam logic [1:0]           c_last_lvl  = 2'd3;

  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic [CNT_WIDTH-1:0] r_prescaler;
  logic [CNT_WIDTH-1:0] w_prescaler_next;
  logic [1:0]           r_level;
  logic [1:0]           w_level_next;
  logic                 r_clear_n;
  logic                 r_load_n;
  logic                 r_final_n;
  logic [1:0]           r_shift;
  logic                 r_level_done;
  logic                 r_win;
  logic                 w_clear_n;
  logic                 w_load_n;
  logic                 w_final_n;
  logic [1:0]           w_shift;
  logic                 w_level_done;
  logic                 w_win;
  logic                 w_tick;
  logic                 w_all_goals;

  assign w_tick      = (r_state == c_run) && (r_prescaler == c_tick_last);
  assign w_all_goals = &SC_LastRegBACKGTYPE_lastpointreg_InBUS;

  // Outputs are registered from the next-state decode so each strobe lines up
  // with the cycle the FSM spends in the corresponding state.
  always_ff @(posedge SC_LastRegBACKGTYPE_CLOCK_50 or posedge SC_LastRegBACKGTYPE_RESET_InHigh) begin
    if (SC_LastRegBACKGTYPE_RESET_InHigh) begin
      r_state      <= c_idle;
      r_prescaler  <= '0;
      r_level      <= 2'd0;
      r_clear_n    <= 1'b1;
      r_load_n     <= 1'b1;
      r_final_n    <= 1'b1;
      r_shift      <= 2'b00;
      r_level_done <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_prescaler  <= w_prescaler_next;
      r_level      <= w_level_next;
      r_clear_n    <= w_clear_n;
      r_load_n     <= w_load_n;
      r_final_n    <= w_final_n;
      r_shift      <= w_shift;
      r_level_done <= w_level_done;
      r_win        <= w_win;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:    if (!SC_LastRegBACKGTYPE_start_InLow) w_next_state = c_clear;
      c_clear:   w_next_state = c_load;
      c_load:    w_next_state = c_run;
      c_run: begin
        if (!SC_LastRegBACKGTYPE_start_InLow)           w_next_state = c_clear;
        else if (!SC_LastRegBACKGTYPE_frogArrive_InLow) w_next_state = c_final;
      end
      c_final:   w_next_state = c_check;
      c_check:   w_next_state = w_all_goals ? c_nextlvl : c_run;
      c_nextlvl: w_next_state = (r_level == c_last_lvl) ? c_win : c_load;
      c_win:     if (!SC_LastRegBACKGTYPE_start_InLow) w_next_state = c_clear;
      default:   w_next_state = c_idle;
    endcase
  end

  always_comb begin
    w_clear_n        = (w_next_state != c_clear);
    w_load_n         = (w_next_state != c_load);
    w_final_n        = (w_next_state != c_final);
    w_win            = (w_next_state == c_win);
    w_level_done     = (w_next_state == c_nextlvl) && (r_level != c_last_lvl);
    w_shift          = 2'b00;
    w_prescaler_next = r_prescaler;
    w_level_next     = r_level;

    // A tick only fires when RUN continues; leaving RUN freezes the count.
    if (r_state == c_load) begin
      w_prescaler_next = '0;
    end else if ((r_state == c_run) && (w_next_state == c_run)) begin
      if (w_tick) begin
        w_prescaler_next = '0;
        w_shift          = r_level[0] ? 2'b10 : 2'b01;
      end else begin
        w_prescaler_next = r_prescaler + CNT_WIDTH'(1);
      end
    end

    if (w_next_state == c_clear) begin
      w_level_next = 2'd0;
    end else if ((r_state == c_nextlvl) && (w_next_state == c_load)) begin
      w_level_next = r_level + 2'd1;
    end
  end

  assign SC_LastRegBACKGTYPE_clear_OutLow             = r_clear_n;
  assign SC_LastRegBACKGTYPE_load_OutLow              = r_load_n;
  assign SC_LastRegBACKGTYPE_shiftselection_Out       = r_shift;
  assign SC_LastRegBACKGTYPE_transitioncounter_OutBUS = r_level;
  assign SC_LastRegBACKGTYPE_LoadFinalRegister_OutLow = r_final_n;
  assign SC_LastRegBACKGTYPE_levelDone_Out            = r_level_done;
  assign SC_LastRegBACKGTYPE_gameWin_Out              = r_win;

endmodule

`default_nettype wire

// File: tb/tb_sc_lastregbackg_controller.sv
// ============================================================================
// tb_sc_lastregbackg_controller: directed bench for the last-row controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_lastregbackg_controller;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b1;
  logic       frog  = 1'b1;
  logic [7:0] bus   = 8'h00;
  logic       clear_n;
  logic       load_n;
  logic [1:0] shift;
  logic [1:0] tc;
  logic       final_n;
  logic       done;
  logic       win;

  int total = 0;
  int bad   = 0;

  sc_lastregbackg_controller #(
    .DATAWIDTH(8),
    .TICK_DIV (4),
    .CNT_WIDTH(25)
  ) dut (
    .SC_LastRegBACKGTYPE_CLOCK_50                (clk),
    .SC_LastRegBACKGTYPE_RESET_InHigh            (rst),
    .SC_LastRegBACKGTYPE_start_InLow             (start),
    .SC_LastRegBACKGTYPE_frogArrive_InLow        (frog),
    .SC_LastRegBACKGTYPE_lastpointreg_InBUS      (bus),
    .SC_LastRegBACKGTYPE_clear_OutLow            (clear_n),
    .SC_LastRegBACKGTYPE_load_OutLow             (load_n),
    .SC_LastRegBACKGTYPE_shiftselection_Out      (shift),
    .SC_LastRegBACKGTYPE_transitioncounter_OutBUS(tc),
    .SC_LastRegBACKGTYPE_LoadFinalRegister_OutLow(final_n),
    .SC_LastRegBACKGTYPE_levelDone_Out           (done),
    .SC_LastRegBACKGTYPE_gameWin_Out             (win)
  );

  always #5 clk = ~clk;

  // Packed output word: {clear, load, shift[1:0], tc[1:0], final, done, win}
  function automatic logic [8:0] ov(input logic c, input logic l, input logic [1:0] sh,
                                    input logic [1:0] t, input logic f, input logic d,
                                    input logic w);
    return {c, l, sh, t, f, d, w};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {clear_n, load_n, shift, tc, final_n, done, win};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // From the LOAD cycle of level old_lvl (<3): capture all goals and advance.
  task automatic advance(input logic [1:0] old_lvl);
    step(); chk("adv_run", ov(1, 1, 2'b00, old_lvl, 1, 0, 0));
    frog = 1'b0; bus = 8'hFF;
    step(); chk("adv_final", ov(1, 1, 2'b00, old_lvl, 0, 0, 0));
    frog = 1'b1;
    step(); chk("adv_check", ov(1, 1, 2'b00, old_lvl, 1, 0, 0));
    step(); chk("adv_nextlvl", ov(1, 1, 2'b00, old_lvl, 1, 1, 0));
    step(); chk("adv_load", ov(1, 0, 2'b00, old_lvl + 2'd1, 1, 0, 0));
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    rst = 1'b0;
    step(); chk("idle", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));

    frog = 1'b0;
    step(); chk("idle_frog", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    frog = 1'b1;
    step(); chk("idle_after_frog", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));

    start = 1'b0;
    step(); chk("start_clear", ov(0, 1, 2'b00, 2'b00, 1, 0, 0));
    start = 1'b1;
    step(); chk("start_load", ov(1, 0, 2'b00, 2'b00, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      step(); chk("run_l0_quiet", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    end
    step(); chk("run_l0_shift1", ov(1, 1, 2'b01, 2'b00, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step(); chk("run_l0_quiet2", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    end
    step(); chk("run_l0_shift2", ov(1, 1, 2'b01, 2'b00, 1, 0, 0));

    // Frog lands in the tick cycle with an incomplete goal pattern.
    for (int i = 0; i < 3; i++) begin
      step(); chk("run_l0_pre_frog", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    end
    frog = 1'b0; bus = 8'b0001_0001;
    step(); chk("frog_tick_final", ov(1, 1, 2'b00, 2'b00, 0, 0, 0));
    frog = 1'b1;
    step(); chk("partial_check", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    step(); chk("resume_run", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    step(); chk("resume_shift", ov(1, 1, 2'b01, 2'b00, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step(); chk("resume_quiet", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    end
    step(); chk("resume_shift2", ov(1, 1, 2'b01, 2'b00, 1, 0, 0));

    advance(2'd0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("run_l1_quiet", ov(1, 1, 2'b00, 2'b01, 1, 0, 0));
    end
    step(); chk("run_l1_shift", ov(1, 1, 2'b10, 2'b01, 1, 0, 0));

    advance(2'd1);
    advance(2'd2);

    step(); chk("l3_run", ov(1, 1, 2'b00, 2'b11, 1, 0, 0));
    frog = 1'b0; bus = 8'hFF;
    step(); chk("l3_final", ov(1, 1, 2'b00, 2'b11, 0, 0, 0));
    frog = 1'b1;
    step(); chk("l3_check", ov(1, 1, 2'b00, 2'b11, 1, 0, 0));
    step(); chk("l3_nextlvl_nodone", ov(1, 1, 2'b00, 2'b11, 1, 0, 0));
    for (int i = 0; i < 6; i++) begin
      step(); chk("win_hold", ov(1, 1, 2'b00, 2'b11, 1, 0, 1));
    end
    frog = 1'b0;
    step(); chk("win_frog", ov(1, 1, 2'b00, 2'b11, 1, 0, 1));
    frog = 1'b1;
    step(); chk("win_after_frog", ov(1, 1, 2'b00, 2'b11, 1, 0, 1));

    start = 1'b0;
    step(); chk("win_restart_clear", ov(0, 1, 2'b00, 2'b00, 1, 0, 0));
    start = 1'b1;
    step(); chk("win_restart_load", ov(1, 0, 2'b00, 2'b00, 1, 0, 0));

    // Reach level 1, then hit reset asynchronously during a shift cycle.
    advance(2'd0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("run2_l1_quiet", ov(1, 1, 2'b00, 2'b01, 1, 0, 0));
    end
    step(); chk("run2_l1_shift", ov(1, 1, 2'b10, 2'b01, 1, 0, 0));
    #2 rst = 1'b1;
    #1 chk("async_reset", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); chk("post_reset_idle", ov(1, 1, 2'b00, 2'b00, 1, 0, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
